// File: rtl/lcd_win_ctrl.sv
// Windowed LCD image controller: holds an IMG_W x IMG_H frame and streams a WIN x WIN window after each command.
// Optional mirror/flip commands (6/7) are built when LCD_MIRROR_EN is defined; otherwise they act as reflash.
module lcd_win_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 6,
  parameter int unsigned IMG_H = 6,
  parameter int unsigned WIN   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned NW = (N > 1) ? $clog2(N + 1) : 1;
  localparam int unsigned XW = $clog2(IMG_W - WIN + 2);
  localparam int unsigned YW = $clog2(IMG_H - WIN + 2);
  localparam int unsigned CW = $clog2(WIN + 1);

  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - WIN);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - WIN);
  localparam logic [XW-1:0] X_CTR = XW'((IMG_W - WIN) / 2);
  localparam logic [YW-1:0] Y_CTR = YW'((IMG_H - WIN) / 2);
  localparam logic [CW-1:0] W_LAST = CW'(WIN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PROC, OUT} state_t;

  state_t         state;
  logic [NW-1:0]  ld_cnt;
  logic [XW-1:0]  ox;
  logic [YW-1:0]  oy;
  logic [CW-1:0]  rr;
  logic [CW-1:0]  cc;
  logic [DW-1:0]  mem [N];
  logic           mirror;
  logic           flip;

  logic           accept_c;
  logic [CW-1:0]  rr_eff_c;
  logic [CW-1:0]  cc_eff_c;
  logic [NW-1:0]  rd_idx_c;

  // A command is taken only from a fully quiet controller.
  assign accept_c = cmd_valid && !busy && (state == IDLE);

  // Window pixel address, with optional row/column reversal.
  always_comb begin
    rr_eff_c = flip   ? (W_LAST - rr) : rr;
    cc_eff_c = mirror ? (W_LAST - cc) : cc;
    rd_idx_c = NW'((32'(oy) + 32'(rr_eff_c)) * 32'(IMG_W) + 32'(ox) + 32'(cc_eff_c));
  end

`ifndef LCD_MIRROR_EN
  assign mirror = 1'b0;
  assign flip   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      output_valid <= 1'b0;
      dataout      <= '0;
      ld_cnt       <= '0;
      ox           <= '0;
      oy           <= '0;
      rr           <= '0;
      cc           <= '0;
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
`ifdef LCD_MIRROR_EN
      mirror       <= 1'b0;
      flip         <= 1'b0;
`endif
    end else begin
      // busy trails the state by one edge so it drops together with output_valid.
      busy         <= (state != IDLE);
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            rr <= '0;
            cc <= '0;
            if (cmd == 3'd1) begin
              state  <= LOAD;
              ld_cnt <= '0;
`ifdef LCD_MIRROR_EN
              mirror <= 1'b0;
              flip   <= 1'b0;
`endif
            end else begin
              state <= PROC;
              case (cmd)
                3'd2: if (ox < X_MAX) ox <= ox + XW'(1);
                3'd3: if (ox != '0)   ox <= ox - XW'(1);
                3'd4: if (oy != '0)   oy <= oy - YW'(1);
                3'd5: if (oy < Y_MAX) oy <= oy + YW'(1);
`ifdef LCD_MIRROR_EN
                3'd6: mirror <= ~mirror;
                3'd7: flip   <= ~flip;
`endif
                default: ;
              endcase
            end
          end
        end
        LOAD: begin
          mem[ld_cnt] <= datain;
          if (ld_cnt == NW'(N - 1)) begin
            ox    <= X_CTR;
            oy    <= Y_CTR;
            state <= OUT;
          end else begin
            ld_cnt <= ld_cnt + NW'(1);
          end
        end
        PROC: state <= OUT;
        OUT: begin
          dataout      <= mem[rd_idx_c];
          output_valid <= 1'b1;
          if (cc == W_LAST) begin
            cc <= '0;
            if (rr == W_LAST) begin
              rr    <= '0;
              state <= IDLE;
            end else begin
              rr <= rr + CW'(1);
            end
          end else begin
            cc <= cc + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl: a frame/origin reference model queues expected window pixels,
// a negedge monitor pops and compares them whenever output_valid is high.
module tb_lcd_win_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned IMG_W = 6;
  localparam int unsigned IMG_H = 6;
  localparam int unsigned WIN   = 3;
  localparam int unsigned N     = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] datain = '0;
  logic [2:0]    cmd = '0;
  logic          cmd_valid = 1'b0;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  lcd_win_ctrl #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  // Reference model state
  logic [DW-1:0] frame    [N];
  logic [DW-1:0] load_pix [N];
  int            ox_m, oy_m;
  bit            mir_m, flp_m;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) frame[i] = '0;
    ox_m = 0; oy_m = 0; mir_m = 0; flp_m = 0;
  endtask

  // Apply a command to the model and queue the window it must produce.
  task automatic model_cmd(input logic [2:0] c);
    case (c)
      3'd1: begin
        for (int i = 0; i < int'(N); i++) frame[i] = load_pix[i];
        ox_m = (IMG_W - WIN) / 2; oy_m = (IMG_H - WIN) / 2;
        mir_m = 0; flp_m = 0;
      end
      3'd2: if (ox_m < int'(IMG_W - WIN)) ox_m++;
      3'd3: if (ox_m > 0) ox_m--;
      3'd4: if (oy_m > 0) oy_m--;
      3'd5: if (oy_m < int'(IMG_H - WIN)) oy_m++;
`ifdef LCD_MIRROR_EN
      3'd6: mir_m = !mir_m;
      3'd7: flp_m = !flp_m;
`endif
      default: ;
    endcase
    for (int j = 0; j < int'(WIN * WIN); j++) begin
      int r, cl;
      r  = j / WIN;
      cl = j % WIN;
      if (mir_m) cl = WIN - 1 - cl;
      if (flp_m) r = WIN - 1 - r;
      exp_q.push_back(frame[(oy_m + r) * IMG_W + ox_m + cl]);
    end
  endtask

  // Monitor: every valid pixel must match the head of the expectation queue.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (reset && output_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pixel: got %0d expected none", dataout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("pixel", int'(dataout), int'(e));
      end
    end
  end

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !output_valid && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: got busy=%0d queue=%0d expected idle", busy, exp_q.size());
    end
  endtask

  task automatic issue(input logic [2:0] c);
    wait_ready();
    @(negedge clk);
    cmd = c; cmd_valid = 1'b1;
    model_cmd(c);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (c == 3'd1) begin
      for (int k = 0; k < int'(N); k++) begin
        datain = load_pix[k];
        @(posedge clk); #1;
      end
    end else begin
      @(posedge clk); #1;
      check("valid_at_T+1", int'(output_valid), 0);
      @(posedge clk); #1;
      check("valid_at_T+2", int'(output_valid), 1);
    end
  endtask

  task automatic load_and_count(input string name);
    wait_ready();
    busy_cnt = 0;
    issue(3'd1);
    wait_ready();
    check(name, busy_cnt, int'(N + WIN * WIN));
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(output_valid), 0);
    check("rst_dataout", int'(dataout), 0);
    @(negedge clk); reset = 1'b1;

    // Reflash on the zeroed frame
    issue(3'd0);

    // Ramp load, then shift right past the clamp
    for (int i = 0; i < int'(N); i++) load_pix[i] = DW'(i + 1);
    load_and_count("load_busy_cycles");
    repeat (4) issue(3'd2);
    issue(3'd5); issue(3'd5);
    issue(3'd3); issue(3'd3); issue(3'd3); issue(3'd3);

    // Shift up to the top clamp and reflash
    load_and_count("load_busy_cycles2");
    issue(3'd4); issue(3'd4); issue(3'd0);

    // Command strobed during a burst is ignored
    issue(3'd0);
    cmd = 3'd2; cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 cmd_valid = 1'b0;
    issue(3'd0);

    // Random frames and command mix
    for (int t = 0; t < 40; t++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 7));
      if (c == 3'd1)
        for (int i = 0; i < int'(N); i++) load_pix[i] = DW'($urandom);
      issue(c);
    end

    // Asynchronous reset at the 4th pixel of a burst
    wait_ready();
    issue(3'd2);
    begin
      int seen = 0;
      for (int i = 0; i < 20 && seen < 4; i++) begin
        @(negedge clk);
        if (output_valid) seen++;
      end
      check("pixels_before_reset", seen, 4);
    end
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", int'(output_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_dataout", int'(dataout), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk); reset = 1'b1;
    issue(3'd0);
    issue(3'd5);

    wait_ready();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_win_ctrl.md
Name: lcd_win_ctrl

Overview:
- Parametrised next-generation LCD image controller.
- Holds an IMG_W x IMG_H frame of DW-bit pixels and accepts 3-bit commands: load, reflash and four window shifts.
- After every command it streams a WIN x WIN display window in raster order to the LCD driver side.
- Sits between the host command interface and the panel data path; replaces the fixed 6x6 / 3x3 controller.

Parameters:
DW, 8, pixel data width in bits
IMG_W, 6, frame width in pixels (>= WIN)
IMG_H, 6, frame height in pixels (>= WIN)
WIN, 3, window edge length (>= 1)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
datain  input  DW  pixel stream during load, raster order (index = y*IMG_W + x)
cmd  input  3  command code: 0 reflash, 1 load, 2 shift right, 3 shift left, 4 shift up, 5 shift down, 6/7 see Optional Feature
cmd_valid  input  1  command strobe
dataout  output  DW  window pixel
output_valid  output  1  dataout qualifier, one pixel per cycle
busy  output  1  high while a command is executing; commands are ignored while high

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; busy = 0; output_valid = 0; dataout = 0.
  - Origin (ox, oy) = (0, 0); frame memory cleared to 0; all counters 0.
  - Reset asserted mid-load or mid-output aborts immediately; no partial completion after release.
- Accept rule: a command is accepted at edge T only if cmd_valid = 1 and busy = 0. cmd_valid while busy = 1 is ignored, with no queuing.
- States: IDLE -> LOAD (cmd 1) or PROC (other cmds) -> OUT -> IDLE.
- LOAD:
  - busy = 1 from edge T+1.
  - Pixel k (k = 0..N-1, N = IMG_W*IMG_H) is sampled at edge T+1+k.
  - At the last sample, origin = ((IMG_W-WIN)/2, (IMG_H-WIN)/2), integer division.
  - Go to OUT.
- PROC:
  - One cycle; origin update is registered at edge T.
  - Shift right: ox = min(ox+1, IMG_W-WIN).
  - Shift left: ox = max(ox-1, 0).
  - Shift up: oy = max(oy-1, 0).
  - Shift down: oy = min(oy+1, IMG_H-WIN).
  - Reflash leaves the origin unchanged.
  - A clamped shift still produces a full output burst.
- OUT:
  - Exactly WIN*WIN consecutive cycles with output_valid = 1.
  - Pixel j = row r = j/WIN, col c = j%WIN; dataout = mem[(oy+r)*IMG_W + ox + c].
  - dataout and output_valid are registered.
  - First valid cycle follows edge T+2 for non-load commands and edge T+N+1 for load.
- busy drops at the same edge output_valid drops after the last pixel. A new command may be accepted at the following edge.
- dataout holds its last value while output_valid = 0; no bubbles inside a burst.
- Counter widths: $clog2 of their maximum count + 1. Unsigned origin arithmetic; clamps are evaluated without underflow.
- Shift or reflash before any load: operates on the zeroed frame.

Optional Feature:
- Macro LCD_MIRROR_EN.
- Defined:
  - cmd 6 toggles a horizontal-mirror flag; cmd 7 toggles a vertical-flip flag.
  - Both then behave as reflash.
  - In OUT: c' = WIN-1-c if mirror set; r' = WIN-1-r if flip set.
  - Flags clear on reset and on load.
- Not defined: cmd 6 and cmd 7 behave exactly as reflash (cmd 0); no flag logic synthesised.

Test Plan:
- Defaults; reset, load pixels 0..35 -> busy high 36+9 cycles; burst 7,8,9,13,14,15,19,20,21 (origin (1,1)).
- After load, shift right three times -> bursts start 8,9,10,...; then 9,10,11,15,16,17,21,22,23; third burst identical (clamped at ox = 3).
- After load, shift up twice -> 1,2,3,7,8,9,13,14,15 both times; reflash repeats the same burst with unchanged origin.
- Assert cmd_valid with cmd 2 during an output burst -> ignored; origin and following burst unchanged.
- Pull reset low at the 4th output pixel -> output_valid, busy, dataout = 0 asynchronously. After release, reflash outputs nine 0s.
- LCD_MIRROR_EN: load, cmd 6 -> 9,8,7,15,14,13,21,20,19; then cmd 7 -> 21,20,19,15,14,13,9,8,7. Without the macro, cmd 6 -> 7,8,9,...,21.
